// File: rtl/cpu_axi_bridge_pkg.sv
// Shared constants for the sram-like to AXI3 bridge: FSM encodings, AXI IDs, access sizes.
package cpu_axi_bridge_pkg;

  typedef logic [2:0] brg_state_t;

  localparam brg_state_t BRG_ST_IDLE    = 3'd0;
  localparam brg_state_t BRG_ST_RD_AR   = 3'd1;
  localparam brg_state_t BRG_ST_RD_R    = 3'd2;
  localparam brg_state_t BRG_ST_WR_AW_W = 3'd3;
  localparam brg_state_t BRG_ST_WR_B    = 3'd4;
  localparam brg_state_t BRG_ST_RESP    = 3'd5;

  localparam int unsigned AXI_ID_INST = 0;
  localparam int unsigned AXI_ID_DATA = 1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI3 subset driven by the bridge; len/burst/lock/cache/prot/wlast are tied off outside.
interface cpu_axi_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arsize, arvalid, rready,
    output awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rid, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  arid, araddr, arsize, arvalid, rready,
    input  awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/cpu_axi_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and the low address bits; size 3 yields no lanes.
module cpu_axi_bridge_wstrb_gen
  import cpu_axi_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  // Decode size/offset into the enabled byte lanes.
  always_comb begin
    wstrb = 4'b0000;
    unique case (size)
      SZ_BYTE: wstrb = 4'b0001 << addr_lo;
      SZ_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Blocking bridge from the core's inst/data sram-like ports to one AXI3 master.
// One transaction in flight; the data port wins arbitration over the inst port.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INST_ID = AXI_ID_INST,
  parameter int unsigned DATA_ID = AXI_ID_DATA
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  cpu_axi_bridge_if.master  axi
);

  brg_state_t        state_q, state_d;
  logic              is_data_q;  // 1: current transaction belongs to the data port
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done_q, w_done_q;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

  logic idle, accept, aw_fire, w_fire, aw_ok, w_ok, r_fire;
  logic [3:0] wstrb;

  assign idle         = (state_q == BRG_ST_IDLE);
  assign data_addr_ok = idle & data_req;
  assign inst_addr_ok = idle & ~data_req & inst_req;
  assign accept       = data_addr_ok | inst_addr_ok;

  assign aw_fire = axi.awvalid & axi.awready;
  assign w_fire  = axi.wvalid & axi.wready;
  // Each write channel counts as done once it has handshaken, now or earlier.
  assign aw_ok   = aw_done_q | aw_fire;
  assign w_ok    = w_done_q | w_fire;
  assign r_fire  = (state_q == BRG_ST_RD_R) & axi.rvalid;

  // Next-state logic for the single-outstanding transaction FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BRG_ST_IDLE:    if (accept) state_d = data_addr_ok & data_wr ? BRG_ST_WR_AW_W : BRG_ST_RD_AR;
      BRG_ST_RD_AR:   if (axi.arready) state_d = BRG_ST_RD_R;
      BRG_ST_RD_R:    if (axi.rvalid) state_d = BRG_ST_RESP;
      BRG_ST_WR_AW_W: if (aw_ok && w_ok) state_d = BRG_ST_WR_B;
      BRG_ST_WR_B:    if (axi.bvalid) state_d = BRG_ST_RESP;
      BRG_ST_RESP:    state_d = BRG_ST_IDLE;
      default:        state_d = BRG_ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= BRG_ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch the granted request at the addr_ok handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_data_q <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
    end else if (accept) begin
      is_data_q <= data_req;
      addr_q    <= data_req ? data_addr : inst_addr;
      size_q    <= data_req ? data_size : inst_size;
      wdata_q   <= data_wdata;
    end
  end

  // Track independent AW and W completion; cleared when a new request is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
    end
  end

  // Capture read data into the owning port's register; it holds until that port's next read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else if (r_fire) begin
      if (is_data_q) data_rdata_q <= axi.rdata;
      else           inst_rdata_q <= axi.rdata;
    end
  end

  cpu_axi_bridge_wstrb_gen u_wstrb_gen (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign inst_data_ok = (state_q == BRG_ST_RESP) & ~is_data_q;
  assign data_data_ok = (state_q == BRG_ST_RESP) & is_data_q;

  assign axi.arid    = is_data_q ? 4'(DATA_ID) : 4'(INST_ID);
  assign axi.araddr  = addr_q;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arvalid = (state_q == BRG_ST_RD_AR);
  assign axi.rready  = (state_q == BRG_ST_RD_R);

  assign axi.awid    = 4'(DATA_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awvalid = (state_q == BRG_ST_WR_AW_W) & ~aw_done_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb;
  assign axi.wvalid  = (state_q == BRG_ST_WR_AW_W) & ~w_done_q;
  assign axi.bready  = (state_q == BRG_ST_WR_B);

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge; the bench plays the AXI slave and the core.
module tb_cpu_axi_bridge;

  logic        clk, resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;

  int vectors = 0;
  int miscompares = 0;

  cpu_axi_bridge_if axi ();

  cpu_axi_bridge dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] t3_addr [5];
  logic [1:0]  t3_size [5];
  logic [3:0]  t3_strb [5];

  initial begin
    t3_addr = '{32'h8000_0100, 32'h8000_0101, 32'h8000_0102, 32'h8000_0103, 32'h8000_0102};
    t3_size = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    t3_strb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100};

    resetn = 1'b0;
    inst_req = 1'b0; inst_size = 2'd2; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    axi.arready = 1'b0; axi.rid = 4'd0; axi.rdata = '0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    chk("rst_valids", {27'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 1: minimum-latency inst read
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'h3C1D_BFC0;
    #1 chk("t1_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    #1 chk("t1_arvalid", {31'd0, axi.arvalid}, 32'd1);
    chk("t1_arid", {28'd0, axi.arid}, 32'd0);
    chk("t1_araddr", axi.araddr, 32'hBFC0_0000);
    chk("t1_arsize", {29'd0, axi.arsize}, 32'd2);
    @(negedge clk);
    #1 chk("t1_rready", {30'd0, axi.rready, axi.arvalid}, 32'b10);
    @(negedge clk);
    #1 chk("t1_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_rdata", inst_rdata, 32'h3C1D_BFC0);
    @(negedge clk);
    #1 chk("t1_data_ok_pulse", {31'd0, inst_data_ok}, 32'd0);

    // 2: simultaneous requests, data first then inst
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000; data_size = 2'd2;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    axi.rdata = 32'h1111_2222;
    #1 chk("t2_oks", {30'd0, data_addr_ok, inst_addr_ok}, 32'b10);
    @(negedge clk);
    data_req = 1'b0;
    #1 chk("t2_arid_data", {28'd0, axi.arid}, 32'd1);
    chk("t2_araddr_data", axi.araddr, 32'h8000_1000);
    chk("t2_inst_wait_ar", {31'd0, inst_addr_ok}, 32'd0);
    @(negedge clk);
    #1 chk("t2_inst_wait_r", {31'd0, inst_addr_ok}, 32'd0);
    @(negedge clk);
    axi.rdata = 32'h3333_4444;
    #1 chk("t2_resp_oks", {29'd0, data_data_ok, inst_data_ok, inst_addr_ok}, 32'b100);
    chk("t2_data_rdata", data_rdata, 32'h1111_2222);
    @(negedge clk);
    #1 chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    #1 chk("t2_arid_inst", {28'd0, axi.arid}, 32'd0);
    chk("t2_araddr_inst", axi.araddr, 32'hBFC0_0004);
    @(negedge clk);
    @(negedge clk);
    #1 chk("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t2_inst_rdata", inst_rdata, 32'h3333_4444);
    chk("t2_data_rdata_hold", data_rdata, 32'h1111_2222);
    @(negedge clk);

    // 3: byte stores to each lane, then a half store to the upper half
    axi.arready = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_addr = t3_addr[i]; data_size = t3_size[i];
      data_wdata = 32'hA5A5_0000 | i;
      #1 chk("t3_addr_ok", {31'd0, data_addr_ok}, 32'd1);
      @(negedge clk);
      data_req = 1'b0;
      #1 chk("t3_wstrb", {28'd0, axi.wstrb}, {28'd0, t3_strb[i]});
      chk("t3_awid", {28'd0, axi.awid}, 32'd1);
      chk("t3_aw_w_valid", {30'd0, axi.awvalid, axi.wvalid}, 32'b11);
      chk("t3_wdata", axi.wdata, 32'hA5A5_0000 | i);
      @(negedge clk);
      #1 chk("t3_bready", {31'd0, axi.bready}, 32'd1);
      @(negedge clk);
      #1 chk("t3_data_ok", {31'd0, data_data_ok}, 32'd1);
      @(negedge clk);
      #1 chk("t3_data_ok_pulse", {31'd0, data_data_ok}, 32'd0);
    end

    // 4: awready two cycles late, wready immediate
    axi.awready = 1'b0;
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0200; data_size = 2'd2;
    data_wdata = 32'h0BAD_F00D;
    #1 chk("t4_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    @(negedge clk);
    data_req = 1'b0;
    #1 chk("t4_entry", {28'd0, axi.wstrb}, 32'hF);
    chk("t4_entry_valids", {30'd0, axi.awvalid, axi.wvalid}, 32'b11);
    @(negedge clk);
    #1 chk("t4_w_dropped", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b100);
    @(negedge clk);
    axi.awready = 1'b1;
    #1 chk("t4_aw_wait", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b100);
    @(negedge clk);
    #1 chk("t4_wr_b", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'b001);
    @(negedge clk);
    #1 chk("t4_data_ok", {31'd0, data_data_ok}, 32'd1);
    @(negedge clk);
    #1 chk("t4_data_ok_pulse", {31'd0, data_data_ok}, 32'd0);

    // 5: rvalid held off 10 cycles with both ports requesting
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    axi.arready = 1'b1; axi.rvalid = 1'b0; axi.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_2000; data_size = 2'd2;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    #1 chk("t5_oks", {30'd0, data_addr_ok, inst_addr_ok}, 32'b10);
    @(negedge clk);
    #1 chk("t5_ar", {30'd0, axi.arvalid, data_addr_ok}, 32'b10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk("t5_wait", {27'd0, axi.rready, inst_addr_ok, data_addr_ok, inst_data_ok,
                         data_data_ok}, 32'b10000);
    end
    @(negedge clk);
    axi.rvalid = 1'b1; data_req = 1'b0; inst_req = 1'b0;
    #1 chk("t5_rready", {31'd0, axi.rready}, 32'd1);
    @(negedge clk);
    #1 chk("t5_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'b10);
    chk("t5_rdata", data_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    #1 chk("t5_data_ok_pulse", {31'd0, data_data_ok}, 32'd0);

    // 6: reset in RD_R, then a clean inst read
    axi.rvalid = 1'b0;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0020;
    #1 chk("t6_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    #1 chk("t6_arvalid", {31'd0, axi.arvalid}, 32'd1);
    @(negedge clk);
    #1 chk("t6_rready", {31'd0, axi.rready}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk("t6_rst_valids", {27'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                             axi.bready}, 32'd0);
    chk("t6_rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    chk("t6_rst_inst_rdata", inst_rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0024;
    #1 chk("t6_re_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    #1 chk("t6_re_araddr", axi.araddr, 32'hBFC0_0024);
    @(negedge clk);
    #1 chk("t6_re_rready", {31'd0, axi.rready}, 32'd1);
    @(negedge clk);
    #1 chk("t6_re_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t6_re_rdata", inst_rdata, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
